// File: rtl/sumador_pkg.sv
// Shared encodings for the round-robin nibble-serial adder/subtractor.
package sumador_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  // Nibble counter width: ceil(log2(n)), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/Sumador_4bits.sv
// 4-bit ripple-carry adder shared by every nibble of an operation.
module Sumador_4bits (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  // Ripple the carry through four full-adder stages.
  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = 4'b0;
    for (int i = 0; i < 4; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/sumador_arbitro_16.sv
// Two-requester round-robin arbiter in front of a nibble-serial add/subtract unit.
module sumador_arbitro_16
  import sumador_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 inclk,
  input  logic                 inrst,
  input  logic                 inreq0,
  input  logic                 inreq1,
  input  logic                 inop0,
  input  logic                 inop1,
  input  logic [4*NIBBLES-1:0] ina_r0,
  input  logic [4*NIBBLES-1:0] inb_r0,
  input  logic [4*NIBBLES-1:0] ina_r1,
  input  logic [4*NIBBLES-1:0] inb_r1,
  output logic                 outgnt0,
  output logic                 outgnt1,
  output logic                 outdone0,
  output logic                 outdone1,
  output logic [4*NIBBLES:0]   outres,
  output logic                 outbusy
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned CntW = cnt_width(NIBBLES);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  op_e             op_q, op_d;
  logic            id_q, id_d;
  logic            last_q, last_d;  // requester granted most recently
  logic            carry_q, carry_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W:0]      res_q, res_d;

  logic            win;
  int unsigned     idx;
  logic [3:0]      nib_a, nib_b, nib_sum;
  logic            nib_cin, nib_cout;

  // Operand slice for the current nibble; subtract feeds ~B with carry-in 1.
  always_comb begin
    idx     = 32'(cnt_q) * 4;
    nib_a   = a_q[idx +: 4];
    nib_b   = b_q[idx +: 4] ^ {4{op_q == OpSub}};
    nib_cin = (cnt_q == '0) ? op_q : carry_q;
  end

  Sumador_4bits u_nib_add (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .cin_i (nib_cin),
    .sum_o (nib_sum),
    .cout_o(nib_cout)
  );

  // Round-robin pick: contested requests go to the one not served last.
  always_comb begin
    win = (inreq0 && inreq1) ? ~last_q : inreq1;
  end

  // Next-state: accept in idle, one nibble per calc cycle, single done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (inreq0 || inreq1) begin
          a_d     = win ? ina_r1 : ina_r0;
          b_d     = win ? inb_r1 : inb_r0;
          op_d    = op_e'(win ? inop1 : inop0);
          id_d    = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d[idx +: 4] = nib_sum;
        carry_d         = nib_cout;
        if (cnt_q == CntW'(NIBBLES - 1)) begin
          res_d   = {nib_cout, acc_d};
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge inclk or posedge inrst) begin
    if (inrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpAdd;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      carry_q <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  always_comb begin
    outgnt0  = (state_q == StCalc) && (cnt_q == '0) && !id_q;
    outgnt1  = (state_q == StCalc) && (cnt_q == '0) && id_q;
    outdone0 = (state_q == StDone) && !id_q;
    outdone1 = (state_q == StDone) && id_q;
    outbusy  = (state_q != StIdle);
    outres   = res_q;
  end

endmodule

// File: tb/tb_sumador_arbitro_16.sv
// Self-checking bench: cycle model of the arbiter plus directed literal checks.
module tb_sumador_arbitro_16;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         inclk = 1'b0;
  logic         inrst = 1'b0;
  logic         inreq0 = 1'b0, inreq1 = 1'b0;
  logic         inop0 = 1'b0, inop1 = 1'b0;
  logic [W-1:0] ina_r0 = '0, inb_r0 = '0, ina_r1 = '0, inb_r1 = '0;
  logic         outgnt0, outgnt1, outdone0, outdone1, outbusy;
  logic [W:0]   outres;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  sumador_arbitro_16 #(.NIBBLES(NIB)) dut (
    .inclk   (inclk),
    .inrst   (inrst),
    .inreq0  (inreq0),
    .inreq1  (inreq1),
    .inop0   (inop0),
    .inop1   (inop1),
    .ina_r0  (ina_r0),
    .inb_r0  (inb_r0),
    .ina_r1  (ina_r1),
    .inb_r1  (inb_r1),
    .outgnt0 (outgnt0),
    .outgnt1 (outgnt1),
    .outdone0(outdone0),
    .outdone1(outdone1),
    .outres  (outres),
    .outbusy (outbusy)
  );

  always #5 inclk = ~inclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: bit W is carry for add, "no borrow" for subtract.
  function automatic logic [W:0] calc(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!op) return {1'b0, a} + {1'b0, b};
    return {(a >= b), W'(a - b)};
  endfunction

  // Model: m_t = cycles since accept (0 idle, 1..NIB calc, NIB+1 done).
  int         m_t = 0;
  logic       m_owner = 1'b0;
  logic       m_last = 1'b1;
  logic [W:0] m_pend = '0;
  logic [W:0] m_res = '0;

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  always @(posedge inclk or posedge inrst) begin
    if (inrst) begin
      m_t    <= 0;
      m_res  <= '0;
      m_last <= 1'b1;
    end else if (m_t == 0) begin
      if (inreq0 || inreq1) begin
        m_owner <= pick(inreq0, inreq1, m_last);
        m_last  <= pick(inreq0, inreq1, m_last);
        m_pend  <= pick(inreq0, inreq1, m_last) ? calc(inop1, ina_r1, inb_r1)
                                                : calc(inop0, ina_r0, inb_r0);
        m_t     <= 1;
      end
    end else if (m_t == NIB + 1) begin
      m_t <= 0;
    end else begin
      if (m_t == NIB) m_res <= m_pend;
      m_t <= m_t + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge inclk) begin
    if (chk_en) begin
      chk("gnt0", 32'(outgnt0), 32'(m_t == 1 && !m_owner));
      chk("gnt1", 32'(outgnt1), 32'(m_t == 1 && m_owner));
      chk("done0", 32'(outdone0), 32'(m_t == NIB + 1 && !m_owner));
      chk("done1", 32'(outdone1), 32'(m_t == NIB + 1 && m_owner));
      chk("busy", 32'(outbusy), 32'(m_t != 0));
      chk("res", 32'(outres), 32'(m_res));
    end
  end

  // sel: 0 gnt0, 1 gnt1, 2 done0, 3 done1, 4 any grant. n = negedges waited.
  task automatic wait_for(input int sel, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge inclk);
      n++;
      case (sel)
        0: ok = outgnt0;
        1: ok = outgnt1;
        2: ok = outdone0;
        3: ok = outdone1;
        default: ok = outgnt0 | outgnt1;
      endcase
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_sel%0d: not seen within 40 cycles (got 0, expected 1)", sel);
    end
  endtask

  task automatic run_op(input string name, input logic id, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W:0] exp, input bit perturb);
    int n;
    bit ok;
    @(negedge inclk);
    if (!id) begin
      inreq0 = 1'b1; inop0 = op; ina_r0 = a; inb_r0 = b;
    end else begin
      inreq1 = 1'b1; inop1 = op; ina_r1 = a; inb_r1 = b;
    end
    wait_for(id ? 1 : 0, n, ok);
    inreq0 = 1'b0;
    inreq1 = 1'b0;
    if (perturb) begin
      @(negedge inclk);
      ina_r0 = ~a;
      inb_r0 = ~b;
      wait_for(id ? 3 : 2, n, ok);
      chk({name, "_lat"}, 32'(n), 32'(NIB - 1));
    end else begin
      wait_for(id ? 3 : 2, n, ok);
      chk({name, "_lat"}, 32'(n), 32'(NIB));
    end
    chk({name, "_res"}, 32'(outres), 32'(exp));
  endtask

  initial begin
    int n, dones;
    bit ok;
    logic who;
    logic [3:0] order;
    logic [3:0] want;
    #2 inrst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 32'(outbusy), 32'd0);
    chk("rst_res", 32'(outres), 32'd0);
    @(negedge inclk);
    @(negedge inclk);
    inrst = 1'b0;

    run_op("add_1234", 1'b0, 1'b0, 16'h1234, 16'h0FCD, 17'h0_2201, 1'b0);
    run_op("sub_5_7", 1'b1, 1'b1, 16'h0005, 16'h0007, 17'h0_FFFE, 1'b0);

    // Both held: grants must alternate starting with requester 0.
    @(negedge inclk);
    inreq0 = 1'b1; inop0 = 1'b0; ina_r0 = 16'h0100; inb_r0 = 16'h0023;
    inreq1 = 1'b1; inop1 = 1'b1; ina_r1 = 16'h0300; inb_r1 = 16'h0001;
    order = '0;
    for (int i = 0; i < 4; i++) begin
      wait_for(4, n, ok);
      who = outgnt1;
      order[i] = who;
      if (i == 3) begin
        inreq0 = 1'b0;
        inreq1 = 1'b0;
      end
    end
    want = 4'b1010;
    chk("rr_order", 32'(order), 32'(want));
    wait_for(3, n, ok);
    chk("rr_last_res", 32'(outres), 32'h0_02FF | 32'h1_0000);

    run_op("add_ffff", 1'b0, 1'b0, 16'hFFFF, 16'h0001, 17'h1_0000, 1'b0);
    run_op("latch", 1'b0, 1'b0, 16'h4321, 16'h1111, 17'h0_5432, 1'b1);

    // Reset during nibble 2 of an operation.
    @(negedge inclk);
    inreq0 = 1'b1; inop0 = 1'b0; ina_r0 = 16'h1111; inb_r0 = 16'h2222;
    wait_for(0, n, ok);
    inreq0 = 1'b0;
    @(negedge inclk);
    @(negedge inclk);
    #1 inrst = 1'b1;
    #1;
    chk("arst_gnt", 32'({outgnt0, outgnt1}), 32'd0);
    chk("arst_done", 32'({outdone0, outdone1}), 32'd0);
    chk("arst_busy", 32'(outbusy), 32'd0);
    chk("arst_res", 32'(outres), 32'd0);
    @(negedge inclk);
    @(negedge inclk);
    inrst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge inclk);
      dones += int'(outdone0) + int'(outdone1);
    end
    chk("arst_no_done", 32'(dones), 32'd0);
    run_op("post_rst", 1'b1, 1'b0, 16'h00AB, 16'h0055, 17'h0_0100, 1'b0);

    @(negedge inclk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sumador_arbitro_16.md
SUMADOR_ARBITRO_16 -- requirements
Module: sumador_arbitro_16

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have inclk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have inrst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have inreq0, inreq1  input  1 each  operation request from requester 0 and requester 1.
REQ-005 SHALL have inop0, inop1  input  1 each  operation select per requester (0 = add A+B, 1 = subtract A-B).
REQ-006 SHALL have ina_r0, inb_r0, ina_r1, inb_r1  input  W each  unsigned operands per requester.
REQ-007 SHALL have outgnt0, outgnt1  output  1 each  one-cycle accept pulse per requester.
REQ-008 SHALL have outdone0, outdone1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 SHALL have outres  output  W+1  result; bit W is the final carry (for subtract: 1 = no borrow).
REQ-010 SHALL have outbusy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on an accept edge, CALC->DONE after NIBBLES CALC cycles, DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL accept a request only at a rising edge where state = IDLE and at least one inreq is high; requests in CALC/DONE are ignored (the requester holds inreq until granted).
REQ-013 SHALL arbitrate round-robin: with one request pending, it wins; with both pending, the requester not granted last wins; after reset requester 0 has priority.
REQ-014 SHALL latch the winner's operands, op and ID at the accept edge; operand changes after that edge do not affect the result.
REQ-015 SHALL drive the winner's outgnt high for exactly the first CALC cycle, and the loser's outgnt low throughout.
REQ-016 SHALL process nibble k (k = 0..NIBBLES-1, LSB first) in CALC cycle k through one shared 4-bit adder, registering the 4 sum bits into result bits [4k+3:4k] and the carry-out into a carry register.
REQ-017 SHALL use carry-in = op for nibble 0 and the registered carry for nibbles 1..NIBBLES-1; for subtract, the B nibble is bitwise inverted before the adder.
REQ-018 SHALL update outres (W sum bits plus final carry) at the edge entering DONE and hold it unchanged until the next DONE entry.
REQ-019 SHALL pulse the owning requester's outdone high for exactly the DONE cycle; the other outdone stays low.
REQ-020 SHALL have latency accept edge -> outdone high of NIBBLES+1 cycles, and one operation per NIBBLES+2 cycles maximum throughput.
REQ-021 SHALL treat inreq still high in IDLE after its own outdone as a new request, subject to REQ-013.
REQ-022 SHALL wrap modulo 2^W with no error flag; overflow/borrow is reported only in outres[W].

Reset
REQ-023 SHALL on inrst asserted, immediately force state IDLE, outres 0, carry register 0, outgnt*/outdone* 0, outbusy 0, round-robin pointer favouring requester 0.
REQ-024 SHALL abort any in-flight operation on reset mid-CALC/DONE, with no outdone pulse for it after reset release.

Structure
REQ-025 SHALL place the state encoding (IDLE, CALC, DONE) and the op encoding (ADD = 0, SUB = 1) in the shared package sumador_pkg.
REQ-026 SHALL instantiate the team's existing 4-bit ripple adder Sumador_4bits exactly once as the shared nibble adder; no other adder logic is allowed.
REQ-027 SHALL use a nibble counter of width ceil(log2(NIBBLES)) bits, minimum 1.

Verification
REQ-028 SHALL cover: req0 add 0x1234+0x0FCD -> outgnt0 pulse, outdone0 5 cycles after accept, outres = 0x0_2201.
REQ-029 SHALL cover: req1 sub 0x0005-0x0007 -> outres = 0x0_FFFE (bit16 = 0, borrow).
REQ-030 SHALL cover: req0 and req1 raised together and held -> grants in order 0, 1, 0, 1; each outdone goes only to its owner.
REQ-031 SHALL cover: add 0xFFFF+0x0001 -> outres = 0x1_0000 (full-carry ripple across all nibbles).
REQ-032 SHALL cover: inrst pulsed during CALC nibble 2 -> all outputs 0 asynchronously, no outdone afterwards, next request after release completes correctly.
REQ-033 SHALL cover: ina_r0 changed the cycle after outgnt0 -> result reflects the operands latched at the accept edge.
